sbox_in_fifo: RTL and testbench
===============================

SBOX_IN_FIFO -- requirements
Module: sbox_in_fifo

Purpose: buffered byte front-end feeding the combined S-box input transform; one entry = {encrypt, G[7:0]}.

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, the number of FIFO entries (power of two, 2..16).
REQ-002 The module SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit, reset, asynchronous and active-high.
REQ-004 The module SHALL have port in_valid, input, 1 bit, upstream byte present.
REQ-005 The module SHALL have port in_ready, output, 1 bit, FIFO able to accept.
REQ-006 The module SHALL have port in_data, input, 8 bits, byte to transform.
REQ-007 The module SHALL have port in_encrypt, input, 1 bit, per-byte mode (1 = forward S-box, 0 = inverse).
REQ-008 The module SHALL have port flush, input, 1 bit, synchronous discard of all entries.
REQ-009 The module SHALL have port out_valid, output, 1 bit, head entry present.
REQ-010 The module SHALL have port out_ready, input, 1 bit, downstream consumes head.
REQ-011 The module SHALL have port G, output, 8 bits, head byte, driving the input transform.
REQ-012 The module SHALL have port encrypt, output, 1 bit, head mode, driving the input transform.
REQ-013 The module SHALL have port count, output, clog2(DEPTH)+1 bits, current occupancy.

Function
REQ-014 Push SHALL occur when in_valid && in_ready && !flush; pop SHALL occur when out_valid && out_ready && !flush.
REQ-015 in_ready SHALL equal (count < DEPTH) && !flush, with no combinational path from out_ready; a full FIFO SHALL NOT accept a push even when a pop occurs in the same cycle.
REQ-016 out_valid SHALL equal (count != 0); first-word fall-through: a byte pushed in cycle N SHALL appear on G/encrypt with out_valid=1 in cycle N+1.
REQ-017 G and encrypt SHALL be the head entry's stored values whenever out_valid=1, and SHALL be 8'h00 and 0 when out_valid=0.
REQ-018 While out_valid=1 and out_ready=0, G, encrypt and out_valid SHALL remain stable.
REQ-019 Simultaneous push and pop SHALL leave count unchanged; the pushed entry SHALL go to the tail, the head SHALL advance.
REQ-020 Entries SHALL emerge in push order; encrypt SHALL travel with its byte, mixed-mode streams SHALL need no bubble.
REQ-021 Write and read pointers SHALL wrap modulo DEPTH; full/empty SHALL derive from count, never pointer equality alone.
REQ-022 flush=1 SHALL set count, write pointer and read pointer to 0 at the next edge; a simultaneous push or pop SHALL be ignored.
REQ-023 Storage contents need no reset; no output SHALL depend on unwritten storage.

Reset
REQ-024 Asserting rst SHALL immediately set count=0, both pointers=0, out_valid=0, G=8'h00, encrypt=0, independent of clk.
REQ-025 in_ready SHALL be 0 while rst=1 and SHALL be 1 in the first cycle after deassertion.
REQ-026 rst asserted mid-stream SHALL discard all entries; no pre-reset byte SHALL appear after deassertion.

Verification
REQ-027 Push 8'h53 enc=1 with out_ready=0 -> next cycle out_valid=1, G=8'h53, encrypt=1, count=1; held stable 5 cycles.
REQ-028 DEPTH=4: push 8'h01,8'h02,8'h03,8'h04 with out_ready=0 -> count=4, in_ready=0; fifth push of 8'h05 rejected; drain yields 01,02,03,04 in order.
REQ-029 Full FIFO, in_valid=1 and out_ready=1 for one cycle -> pop only, count 4->3, in_ready=1 next cycle.
REQ-030 count=2, continuous push+pop 10 cycles with alternating encrypt -> count stays 2, pointers wrap, bytes and modes emerge unchanged in order.
REQ-031 count=3, flush=1 with in_valid=1 -> next cycle count=0, out_valid=0, G=8'h00; pushed byte absent.
REQ-032 count=3, rst pulse mid-cycle -> out_valid=0, G=8'h00, count=0 immediately; after release in_ready=1, out_valid=0.

Source files
------------

// File: rtl/sbox_in_fifo.sv
// sbox_in_fifo
//   Buffered byte front-end for the combined S-box input transform.
//   Each entry is {encrypt, G[7:0]}; first-word fall-through, so the head
//   entry is presented on G/encrypt in the cycle after it is pushed.
//
// Ports
//   clk         single clock, all state on rising edge
//   rst         asynchronous active-high reset
//   in_valid    upstream byte present
//   in_ready    FIFO able to accept (not full, not flushing, not in reset)
//   in_data     byte to transform
//   in_encrypt  per-byte mode (1 = forward S-box, 0 = inverse)
//   flush       synchronous discard of all entries
//   out_valid   head entry present
//   out_ready   downstream consumes head
//   G           head byte (8'h00 when empty)
//   encrypt     head mode (0 when empty)
//   count       current occupancy, clog2(DEPTH)+1 bits
module sbox_in_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               in_data,
  input  logic                     in_encrypt,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               G,
  output logic                     encrypt,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] cnt;
  logic          push;
  logic          pop;

  // in_ready looks only at occupancy, flush and reset: a full FIFO refuses
  // a push even if the head is popped in the same cycle, which keeps
  // out_ready off the in_ready path.
  always_comb begin
    in_ready  = !rst && !flush && (cnt < FULL);
    out_valid = (cnt != '0);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready && !flush;
    G         = '0;
    encrypt   = 1'b0;
    if (out_valid) begin
      G       = mem[rptr][7:0];
      encrypt = mem[rptr][8];
    end
    count     = cnt;
  end

  // Storage carries no reset; it is only observed when cnt says it is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= {in_encrypt, in_data};
    end
  end

  // Pointers are exactly AW bits, so increment wraps modulo DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_sbox_in_fifo.sv
module tb_sbox_in_fifo;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_data;
  logic          in_encrypt;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    G;
  logic          encrypt;
  logic [CW-1:0] count;

  int nerr = 0;
  int nchk = 0;

  // Reference: an ordered queue of {encrypt, byte} entries.
  logic [8:0] q[$];

  sbox_in_fifo #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_encrypt (in_encrypt),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .G          (G),
    .encrypt    (encrypt),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         iv;
    logic [7:0] d;
    bit         e;
    bit         f;
    bit         ordy;
    bit         ev;
    logic [7:0] eg;
    bit         ee;
    int         ec;
    bit         er;
  } vec_t;

  vec_t vecs[21];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic setv(input int i, input bit iv, input logic [7:0] d, input bit e,
                      input bit f, input bit ordy, input bit ev, input logic [7:0] eg,
                      input bit ee, input int ec, input bit er);
    vecs[i] = '{iv, d, e, f, ordy, ev, eg, ee, ec, er};
  endtask

  task automatic check_model(input string tag, input bit f);
    logic [8:0] head;
    head = (q.size() != 0) ? q[0] : 9'h000;
    chk({tag, ".out_valid"}, out_valid, q.size() != 0);
    chk({tag, ".G"}, G, head[7:0]);
    chk({tag, ".encrypt"}, encrypt, head[8]);
    chk({tag, ".count"}, count, q.size());
    chk({tag, ".in_ready"}, in_ready, (q.size() < DEPTH) && !f);
  endtask

  // One clock of stimulus, applied to DUT and reference alike.
  task automatic cyc(input string tag, input bit iv, input logic [7:0] d, input bit e,
                     input bit f, input bit ordy);
    bit mpush;
    bit mpop;
    in_valid   = iv;
    in_data    = d;
    in_encrypt = e;
    flush      = f;
    out_ready  = ordy;
    mpush = iv && !f && (q.size() < DEPTH);
    mpop  = ordy && !f && (q.size() != 0);
    @(posedge clk);
    #1;
    if (f) begin
      q.delete();
    end else begin
      if (mpop) void'(q.pop_front());
      if (mpush) q.push_back({e, d});
    end
    check_model(tag, f);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    chk("rst.out_valid", out_valid, 1'b0);
    chk("rst.G", G, 8'h00);
    chk("rst.encrypt", encrypt, 1'b0);
    chk("rst.count", count, 0);
    chk("rst.in_ready", in_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    #1;
    chk("rst.in_ready_after", in_ready, 1'b1);
    chk("rst.out_valid_after", out_valid, 1'b0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    in_encrypt = 1'b0;
    flush      = 1'b0;
    out_ready  = 1'b0;

    //    idx iv  data   e  f  ordy  ev  G      ee cnt rdy
    setv(0,  1, 8'h53, 1, 0, 0,    1, 8'h53, 1, 1,  1);
    setv(1,  0, 8'h00, 0, 0, 0,    1, 8'h53, 1, 1,  1);
    setv(2,  0, 8'h00, 0, 0, 0,    1, 8'h53, 1, 1,  1);
    setv(3,  0, 8'h00, 0, 0, 0,    1, 8'h53, 1, 1,  1);
    setv(4,  0, 8'h00, 0, 0, 0,    1, 8'h53, 1, 1,  1);
    setv(5,  0, 8'h00, 0, 0, 0,    1, 8'h53, 1, 1,  1);
    setv(6,  0, 8'h00, 0, 0, 1,    0, 8'h00, 0, 0,  1);
    setv(7,  1, 8'h01, 0, 0, 0,    1, 8'h01, 0, 1,  1);
    setv(8,  1, 8'h02, 1, 0, 0,    1, 8'h01, 0, 2,  1);
    setv(9,  1, 8'h03, 0, 0, 0,    1, 8'h01, 0, 3,  1);
    setv(10, 1, 8'h04, 1, 0, 0,    1, 8'h01, 0, 4,  0);
    setv(11, 1, 8'h05, 0, 0, 0,    1, 8'h01, 0, 4,  0);
    setv(12, 1, 8'h06, 1, 0, 1,    1, 8'h02, 1, 3,  1);
    setv(13, 0, 8'h00, 0, 0, 1,    1, 8'h03, 0, 2,  1);
    setv(14, 0, 8'h00, 0, 0, 1,    1, 8'h04, 1, 1,  1);
    setv(15, 0, 8'h00, 0, 0, 1,    0, 8'h00, 0, 0,  1);
    setv(16, 1, 8'h11, 1, 0, 0,    1, 8'h11, 1, 1,  1);
    setv(17, 1, 8'h22, 0, 0, 0,    1, 8'h11, 1, 2,  1);
    setv(18, 1, 8'h33, 1, 0, 0,    1, 8'h11, 1, 3,  1);
    setv(19, 1, 8'h44, 0, 1, 0,    0, 8'h00, 0, 0,  0);
    setv(20, 0, 8'h00, 0, 0, 0,    0, 8'h00, 0, 0,  1);

    do_reset();

    foreach (vecs[i]) begin
      in_valid   = vecs[i].iv;
      in_data    = vecs[i].d;
      in_encrypt = vecs[i].e;
      flush      = vecs[i].f;
      out_ready  = vecs[i].ordy;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d.out_valid", i), out_valid, vecs[i].ev);
      chk($sformatf("vec%0d.G", i), G, vecs[i].eg);
      chk($sformatf("vec%0d.encrypt", i), encrypt, vecs[i].ee);
      chk($sformatf("vec%0d.count", i), count, vecs[i].ec);
      chk($sformatf("vec%0d.in_ready", i), in_ready, vecs[i].er);
    end

    // Steady push+pop at count=2 with alternating modes; pointers wrap.
    cyc("pp.fill0", 1, 8'hA0, 1, 0, 0);
    cyc("pp.fill1", 1, 8'hA1, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cyc($sformatf("pp.%0d", i), 1, 8'hB0 + 8'(i), (i % 2) == 0, 0, 1);
    end

    // Mid-cycle reset with three entries held.
    cyc("mr.drain0", 0, 8'h00, 0, 0, 1);
    cyc("mr.drain1", 0, 8'h00, 0, 0, 1);
    cyc("mr.fill0", 1, 8'hC1, 1, 0, 0);
    cyc("mr.fill1", 1, 8'hC2, 0, 0, 0);
    cyc("mr.fill2", 1, 8'hC3, 1, 0, 0);
    in_valid = 1'b0;
    #2;
    do_reset();
    cyc("mr.post", 0, 8'h00, 0, 0, 1);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      cyc("rnd", $urandom_range(0, 3) != 0, 8'($urandom), 1'($urandom),
          $urandom_range(0, 19) == 0, 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
